// File: rtl/ff_sr_pkg.sv
// Shared types for the iCE40UP global set/reset controller.
// State and mode encodings plus the idle cbit value.
package ff_sr_pkg;

   typedef enum logic [2:0] {
      PUR   = 3'd0,
      IDLE  = 3'd1,
      SETUP = 3'd2,
      PULSE = 3'd3,
      GUARD = 3'd4,
      DONE  = 3'd5
   } sr_state_t;

   typedef enum logic [1:0] {
      SYNC_RST  = 2'b00,
      SYNC_SET  = 2'b01,
      ASYNC_RST = 2'b10,
      ASYNC_SET = 2'b11
   } sr_mode_t;

   localparam logic [1:0] CBIT_IDLE = 2'b00;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker; search starts one past the
// previous winner so every requester is reached within N grants.
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   input  logic          en,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx
);

   always_comb begin
      int   j;
      logic found;
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 1; k <= N; k++) begin
         j = (int'(last) + k) % N;
         if (en && !found && req[j]) begin
            found  = 1'b1;
            gnt[j] = 1'b1;
            idx    = IW'(j);
         end
      end
   end

endmodule

// File: rtl/ff_sr_ctrl.sv
// Power-up reset generator and sequencer for the shared S_R/cbit bus.
// cbit only moves while s_r is low on both sides of the change.
module ff_sr_ctrl
   import ff_sr_pkg::*;
#(
   parameter int NREQ       = 4,
   parameter int PUR_CYCLES = 16,
   parameter int LEN_W      = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [2*NREQ-1:0]     req_mode,
   input  logic [LEN_W*NREQ-1:0] req_len,
   output logic [NREQ-1:0]       gnt,
   output logic                  busy,
   output logic                  purst,
   output logic                  s_r,
   output logic [1:0]            cbit
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int PW = (PUR_CYCLES > 1) ? $clog2(PUR_CYCLES) : 1;

   sr_state_t        state;
   logic [PW-1:0]    pur_cnt;
   logic [LEN_W-1:0] pulse_cnt;
   logic [IW-1:0]    idx_q;
   logic [IW-1:0]    last;

   logic [NREQ-1:0]  arb_gnt;
   logic [IW-1:0]    arb_idx;
   logic [LEN_W-1:0] win_len;
   sr_mode_t         win_mode;

   rr_arbiter #(.N(NREQ)) u_arb (
      .req  (req),
      .last (last),
      .en   (state == IDLE),
      .gnt  (arb_gnt),
      .idx  (arb_idx)
   );

   assign win_len  = req_len[arb_idx*LEN_W +: LEN_W];
   assign win_mode = sr_mode_t'(req_mode[{arb_idx, 1'b0} +: 2]);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= PUR;
         pur_cnt   <= '0;
         pulse_cnt <= '0;
         idx_q     <= '0;
         last      <= IW'(NREQ - 1);
         purst     <= 1'b1;
         s_r       <= 1'b0;
         cbit      <= CBIT_IDLE;
         gnt       <= '0;
         busy      <= 1'b1;
      end else begin
         unique case (state)
            PUR: begin
               if (pur_cnt == PW'(PUR_CYCLES - 1)) begin
                  state <= IDLE;
                  purst <= 1'b0;
                  busy  <= 1'b0;
               end else begin
                  pur_cnt <= pur_cnt + 1'b1;
               end
            end
            IDLE: begin
               if (|arb_gnt) begin
                  // Mode and length are frozen here for the whole sequence
                  idx_q     <= arb_idx;
                  cbit      <= win_mode;
                  pulse_cnt <= (win_len == '0) ? LEN_W'(1) : win_len;
                  state     <= SETUP;
                  busy      <= 1'b1;
               end
            end
            SETUP: begin
               state <= PULSE;
               s_r   <= 1'b1;
            end
            PULSE: begin
               if (pulse_cnt == LEN_W'(1)) begin
                  state <= GUARD;
                  s_r   <= 1'b0;
               end else begin
                  pulse_cnt <= pulse_cnt - 1'b1;
               end
            end
            GUARD: begin
               state <= DONE;
               gnt   <= NREQ'(1) << idx_q;
            end
            DONE: begin
               state <= IDLE;
               gnt   <= '0;
               last  <= idx_q;
               busy  <= 1'b0;
               cbit  <= CBIT_IDLE;
            end
            default: begin
               state <= PUR;
               purst <= 1'b1;
               s_r   <= 1'b0;
               cbit  <= CBIT_IDLE;
               gnt   <= '0;
               busy  <= 1'b1;
            end
         endcase
      end
   end

endmodule
